// File: rtl/fixed_point_arithmetic_pkg.sv
// Shared types and helpers for the FixedPointArithmetic add/subtract datapath.
package fixed_point_arithmetic_pkg;

  localparam int BLK_MAX = 64;

  typedef enum logic {OP_ADD, OP_SUB} add_op_e;

  // Per-stage control that travels alongside the partial sum.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Group propagate over the low w bits; bits at or above w are ignored.
  function automatic logic blk_propagate(input logic [BLK_MAX-1:0] a,
                                         input logic [BLK_MAX-1:0] b,
                                         input int w);
    logic p;
    p = 1'b1;
    for (int i = 0; i < BLK_MAX; i++)
      if (i < w) p = p & (a[i] ^ b[i]);
    return p;
  endfunction

endpackage

// File: rtl/carry_skip_block.sv
// Combinational K-bit ripple block whose carry-out bypasses the ripple chain
// when every bit propagates.
module carry_skip_block
  import fixed_point_arithmetic_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic ripple_co;
  logic pblk;

  always_comb begin : ripple
    logic carry;
    carry    = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (i == K - 1) c_msb_in = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    ripple_co = carry;
  end

  assign pblk = blk_propagate(BLK_MAX'(a), BLK_MAX'(b), K);
  // When not all bits propagate, the ripple result equals the group generate.
  assign cout = pblk ? cin : ripple_co;

endmodule

// File: rtl/pipelined_carry_skip_add.sv
// Pipelined carry-skip add/subtract: one K-bit block resolved per stage,
// valid/ready stream with a single global advance enable.
module pipelined_carry_skip_add
  import fixed_point_arithmetic_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co,
  output logic         ov
);

  localparam int L = N / K;

  if (N % K != 0) begin : g_bad_k
    $error("pipelined_carry_skip_add: N must be a multiple of K");
  end
  if (K > BLK_MAX) begin : g_bad_blk
    $error("pipelined_carry_skip_add: K exceeds BLK_MAX");
  end

  logic    en;
  add_op_e op;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign op       = sub ? OP_SUB : OP_ADD;

  for (genvar i = 0; i < L; i++) begin : g_stage
    // Operands shrink by one block per stage; the sum grows by one block.
    localparam int RW = N - i * K;

    logic [RW-1:0]      a_in, b_in;
    logic               cin, vin;
    logic [(i+1)*K-1:0] sum_nxt, sum_q;
    logic [K-1:0]       s_blk;
    logic               cout_blk, msb_blk;
    stage_ctl_t         ctl_q;

    if (i == 0) begin : g_src
      assign a_in    = a;
      assign b_in    = (op == OP_SUB) ? ~b : b;
      assign cin     = (op == OP_SUB) ? 1'b1 : ci;
      assign vin     = in_valid;
      assign sum_nxt = s_blk;
    end else begin : g_src
      assign a_in    = g_stage[i-1].g_ops.a_q;
      assign b_in    = g_stage[i-1].g_ops.b_q;
      assign cin     = g_stage[i-1].ctl_q.carry;
      assign vin     = g_stage[i-1].ctl_q.valid;
      assign sum_nxt = {s_blk, g_stage[i-1].sum_q};
    end

    carry_skip_block #(.K(K)) u_blk (
      .a        (a_in[K-1:0]),
      .b        (b_in[K-1:0]),
      .cin      (cin),
      .s        (s_blk),
      .cout     (cout_blk),
      .c_msb_in (msb_blk)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (en) begin
        ctl_q <= '{valid: vin, carry: cout_blk};
        sum_q <= sum_nxt;
      end
    end

    if (i < L - 1) begin : g_ops
      logic [RW-K-1:0] a_q, b_q;
      logic            unused_msb;

      // Carry into a block MSB only matters for the topmost block.
      assign unused_msb = msb_blk;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[RW-1:K];
          b_q <= b_in[RW-1:K];
        end
      end
    end else begin : g_last
      logic c_msb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     c_msb_q <= 1'b0;
        else if (en) c_msb_q <= msb_blk;
      end
    end
  end

  assign out_valid = g_stage[L-1].ctl_q.valid;
  assign c         = g_stage[L-1].sum_q;
  assign co        = g_stage[L-1].ctl_q.carry;
  assign ov        = g_stage[L-1].g_last.c_msb_q ^ g_stage[L-1].ctl_q.carry;

endmodule
